bilinear_coord_gen: RTL and testbench

Upstream stage of the bilinear scaler. Walks the destination raster, maps each output pixel to a fixed-point source coordinate, and issues four synchronous RAM reads for the 2×2 source neighbourhood. It then presents the four pixels plus the four 10-bit weights, with `en_b`, directly to `bilinear_cal`. One output pixel per clock while a frame is running; no back-pressure.

---
 rtl/bilinear_pkg.sv | 15 +
 rtl/bilinear_axis_map.sv | 31 +++
 rtl/bilinear_coord_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_bilinear_coord_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bilinear_pkg.sv
// Constants and FSM encoding shared by the bilinear scaler front end and bilinear_cal.
package bilinear_pkg;

   localparam int FRAC_W   = 9;
   localparam int COEF_ONE = 512;
   localparam int COEF_W   = 10;
   localparam int PIX_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/bilinear_axis_map.sv
// One axis of the coordinate decode: integer/fraction split, edge clamp and weight pair.
module bilinear_axis_map
   import bilinear_pkg::*;
#(
   parameter int DIM_W = 11
) (
   input  logic [DIM_W+FRAC_W-1:0] i_acc,
   input  logic [DIM_W-1:0]        i_n,
   output logic [DIM_W-1:0]        o_p0,
   output logic [DIM_W-1:0]        o_p1,
   output logic [COEF_W-1:0]       o_w0,
   output logic [COEF_W-1:0]       o_w1
);

   logic [DIM_W-1:0]  w_int;
   logic [FRAC_W-1:0] w_frac;
   logic [DIM_W-1:0]  w_last;
   logic [DIM_W:0]    w_next;

   assign w_int  = i_acc[DIM_W+FRAC_W-1:FRAC_W];
   assign w_frac = i_acc[FRAC_W-1:0];
   assign w_last = i_n - DIM_W'(1);
   // One extra bit so the right/bottom neighbour of index 2047 cannot wrap to 0.
   assign w_next = {1'b0, w_int} + (DIM_W+1)'(1);

   assign o_p0 = (w_int > w_last) ? w_last : w_int;
   assign o_p1 = (w_next > {1'b0, w_last}) ? w_last : w_next[DIM_W-1:0];
   assign o_w0 = COEF_W'(COEF_ONE) - COEF_W'(w_frac);
   assign o_w1 = COEF_W'(w_frac);

endmodule

// File: rtl/bilinear_coord_gen.sv
// Destination raster walker: maps each output pixel to a 2x2 source neighbourhood,
// issues four RAM reads and presents pixels plus weights to bilinear_cal with en_b.
module bilinear_coord_gen #(
   parameter int DIM_W  = 11,
   parameter int FRAC_W = 9,
   parameter int ADDR_W = 20
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [DIM_W-1:0]                  src_w,
   input  logic [DIM_W-1:0]                  src_h,
   input  logic [DIM_W-1:0]                  dst_w,
   input  logic [DIM_W-1:0]                  dst_h,
   input  logic [DIM_W+FRAC_W-1:0]           step_x,
   input  logic [DIM_W+FRAC_W-1:0]           step_y,
   output logic                              busy,
   output logic                              done,
   output logic                              rd_en,
   output logic [ADDR_W-1:0]                 rd_addr0,
   output logic [ADDR_W-1:0]                 rd_addr1,
   output logic [ADDR_W-1:0]                 rd_addr2,
   output logic [ADDR_W-1:0]                 rd_addr3,
   input  logic [bilinear_pkg::PIX_W-1:0]    rd_data0,
   input  logic [bilinear_pkg::PIX_W-1:0]    rd_data1,
   input  logic [bilinear_pkg::PIX_W-1:0]    rd_data2,
   input  logic [bilinear_pkg::PIX_W-1:0]    rd_data3,
   output logic [bilinear_pkg::COEF_W-1:0]   coefficient1,
   output logic [bilinear_pkg::COEF_W-1:0]   coefficient2,
   output logic [bilinear_pkg::COEF_W-1:0]   coefficient3,
   output logic [bilinear_pkg::COEF_W-1:0]   coefficient4,
   output logic [bilinear_pkg::PIX_W-1:0]    doutbx,
   output logic [bilinear_pkg::PIX_W-1:0]    doutbx1,
   output logic [bilinear_pkg::PIX_W-1:0]    doutby,
   output logic [bilinear_pkg::PIX_W-1:0]    doutby1,
   output logic                              en_b,
   output logic [1:0]                        o_dbg_state
);
   import bilinear_pkg::*;

   localparam int ACC_W = DIM_W + FRAC_W;

   state_t              r_state;
   logic [DIM_W-1:0]    r_src_w, r_src_h, r_dst_w, r_dst_h;
   logic [ACC_W-1:0]    r_step_x, r_step_y;
   logic [ACC_W-1:0]    r_acc_x, r_acc_y;
   logic [DIM_W-1:0]    r_out_x, r_out_y;
   logic                r_busy, r_done;

   logic                r_s0_v;
   logic [ACC_W-1:0]    r_s0_acc_x, r_s0_acc_y;

   logic                r_s1_v;
   logic [DIM_W-1:0]    r_s1_x0, r_s1_x1;
   logic [ADDR_W-1:0]   r_s1_row0, r_s1_row1;
   logic [COEF_W-1:0]   r_s1_cx0, r_s1_cx1, r_s1_cy0, r_s1_cy1;

   logic [COEF_W-1:0]   r_s2_c1, r_s2_c2, r_s2_c3, r_s2_c4;
   logic                r_s3_v;
   logic [COEF_W-1:0]   r_s3_c1, r_s3_c2, r_s3_c3, r_s3_c4;

   logic [DIM_W-1:0]    w_x0, w_x1, w_y0, w_y1;
   logic [COEF_W-1:0]   w_cx0, w_cx1, w_cy0, w_cy1;
   logic [ADDR_W-1:0]   w_prod0, w_prod1;
   logic                w_pipe_empty;

   assign busy        = r_busy;
   assign done        = r_done;
   assign o_dbg_state = r_state;
   // Only the output stage is still occupied: this is the edge that retires the last pixel.
   assign w_pipe_empty = en_b && !r_s0_v && !r_s1_v && !rd_en && !r_s3_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_src_w    <= '0;
         r_src_h    <= '0;
         r_dst_w    <= '0;
         r_dst_h    <= '0;
         r_step_x   <= '0;
         r_step_y   <= '0;
         r_acc_x    <= '0;
         r_acc_y    <= '0;
         r_out_x    <= '0;
         r_out_y    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_s0_v     <= 1'b0;
         r_s0_acc_x <= '0;
         r_s0_acc_y <= '0;
      end else begin
         r_done <= 1'b0;
         r_s0_v <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !r_done) begin
                  r_src_w  <= src_w;
                  r_src_h  <= src_h;
                  r_dst_w  <= dst_w;
                  r_dst_h  <= dst_h;
                  r_step_x <= step_x;
                  r_step_y <= step_y;
                  r_acc_x  <= '0;
                  r_acc_y  <= '0;
                  r_out_x  <= '0;
                  r_out_y  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_s0_v     <= 1'b1;
               r_s0_acc_x <= r_acc_x;
               r_s0_acc_y <= r_acc_y;
               if (r_out_x == r_dst_w - DIM_W'(1)) begin
                  r_out_x <= '0;
                  r_acc_x <= '0;
                  r_acc_y <= r_acc_y + r_step_y;
                  r_out_y <= r_out_y + DIM_W'(1);
                  if (r_out_y == r_dst_h - DIM_W'(1)) r_state <= DRAIN;
               end else begin
                  r_out_x <= r_out_x + DIM_W'(1);
                  r_acc_x <= r_acc_x + r_step_x;
               end
            end
            DRAIN: begin
               if (w_pipe_empty) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   bilinear_axis_map #(.DIM_W(DIM_W)) u_map_x (
      .i_acc (r_s0_acc_x),
      .i_n   (r_src_w),
      .o_p0  (w_x0),
      .o_p1  (w_x1),
      .o_w0  (w_cx0),
      .o_w1  (w_cx1)
   );

   bilinear_axis_map #(.DIM_W(DIM_W)) u_map_y (
      .i_acc (r_s0_acc_y),
      .i_n   (r_src_h),
      .o_p0  (w_y0),
      .o_p1  (w_y1),
      .o_w0  (w_cy0),
      .o_w1  (w_cy1)
   );

   assign w_prod0 = ADDR_W'(w_y0) * ADDR_W'(r_src_w);
   assign w_prod1 = ADDR_W'(w_y1) * ADDR_W'(r_src_w);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v       <= 1'b0;
         r_s1_x0      <= '0;
         r_s1_x1      <= '0;
         r_s1_row0    <= '0;
         r_s1_row1    <= '0;
         r_s1_cx0     <= '0;
         r_s1_cx1     <= '0;
         r_s1_cy0     <= '0;
         r_s1_cy1     <= '0;
         rd_en        <= 1'b0;
         rd_addr0     <= '0;
         rd_addr1     <= '0;
         rd_addr2     <= '0;
         rd_addr3     <= '0;
         r_s2_c1      <= '0;
         r_s2_c2      <= '0;
         r_s2_c3      <= '0;
         r_s2_c4      <= '0;
         r_s3_v       <= 1'b0;
         r_s3_c1      <= '0;
         r_s3_c2      <= '0;
         r_s3_c3      <= '0;
         r_s3_c4      <= '0;
         en_b         <= 1'b0;
         doutbx       <= '0;
         doutbx1      <= '0;
         doutby       <= '0;
         doutby1      <= '0;
         coefficient1 <= '0;
         coefficient2 <= '0;
         coefficient3 <= '0;
         coefficient4 <= '0;
      end else begin
         r_s1_v <= r_s0_v;
         if (r_s0_v) begin
            r_s1_x0   <= w_x0;
            r_s1_x1   <= w_x1;
            r_s1_row0 <= w_prod0;
            r_s1_row1 <= w_prod1;
            r_s1_cx0  <= w_cx0;
            r_s1_cx1  <= w_cx1;
            r_s1_cy0  <= w_cy0;
            r_s1_cy1  <= w_cy1;
         end
         rd_en <= r_s1_v;
         if (r_s1_v) begin
            rd_addr0 <= r_s1_row0 + ADDR_W'(r_s1_x0);
            rd_addr1 <= r_s1_row0 + ADDR_W'(r_s1_x1);
            rd_addr2 <= r_s1_row1 + ADDR_W'(r_s1_x0);
            rd_addr3 <= r_s1_row1 + ADDR_W'(r_s1_x1);
            r_s2_c1  <= r_s1_cx0;
            r_s2_c2  <= r_s1_cx1;
            r_s2_c3  <= r_s1_cy0;
            r_s2_c4  <= r_s1_cy1;
         end
         // Weights ride alongside the RAM access so they line up with rd_data.
         r_s3_v <= rd_en;
         if (rd_en) begin
            r_s3_c1 <= r_s2_c1;
            r_s3_c2 <= r_s2_c2;
            r_s3_c3 <= r_s2_c3;
            r_s3_c4 <= r_s2_c4;
         end
         en_b <= r_s3_v;
         if (r_s3_v) begin
            doutbx       <= rd_data0;
            doutbx1      <= rd_data1;
            doutby       <= rd_data2;
            doutby1      <= rd_data3;
            coefficient1 <= r_s3_c1;
            coefficient2 <= r_s3_c2;
            coefficient3 <= r_s3_c3;
            coefficient4 <= r_s3_c4;
         end
      end
   end

endmodule

// File: tb/tb_bilinear_coord_gen.sv
// Bench for bilinear_coord_gen: directed frames against a raster-level reference model.
module tb_bilinear_coord_gen;

   localparam int DIM_W  = 11;
   localparam int FRAC_W = 9;
   localparam int ADDR_W = 20;
   localparam int ACC_W  = DIM_W + FRAC_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [DIM_W-1:0]  src_w = 1, src_h = 1, dst_w = 1, dst_h = 1;
   logic [ACC_W-1:0]  step_x = 512, step_y = 512;
   logic              busy, done, rd_en, en_b;
   logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
   logic [7:0]        rd_data0 = 0, rd_data1 = 0, rd_data2 = 0, rd_data3 = 0;
   logic [9:0]        coefficient1, coefficient2, coefficient3, coefficient4;
   logic [7:0]        doutbx, doutbx1, doutby, doutby1;
   logic [1:0]        dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [79:0] exp_addr_q[$];
   logic [71:0] exp_out_q[$];

   logic [19:0] cap_a0[64];
   logic [19:0] cap_a1[64];
   logic [7:0]  cap_dx[64];
   logic [9:0]  cap_c1[64];
   logic [9:0]  cap_c2[64];
   logic [9:0]  cap_c3[64];
   logic [9:0]  cap_c4[64];

   bilinear_coord_gen #(.DIM_W(DIM_W), .FRAC_W(FRAC_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .src_w        (src_w),
      .src_h        (src_h),
      .dst_w        (dst_w),
      .dst_h        (dst_h),
      .step_x       (step_x),
      .step_y       (step_y),
      .busy         (busy),
      .done         (done),
      .rd_en        (rd_en),
      .rd_addr0     (rd_addr0),
      .rd_addr1     (rd_addr1),
      .rd_addr2     (rd_addr2),
      .rd_addr3     (rd_addr3),
      .rd_data0     (rd_data0),
      .rd_data1     (rd_data1),
      .rd_data2     (rd_data2),
      .rd_data3     (rd_data3),
      .coefficient1 (coefficient1),
      .coefficient2 (coefficient2),
      .coefficient3 (coefficient3),
      .coefficient4 (coefficient4),
      .doutbx       (doutbx),
      .doutbx1      (doutbx1),
      .doutby       (doutby),
      .doutby1      (doutby1),
      .en_b         (en_b),
      .o_dbg_state  (dbg_state)
   );

   // Clock and source RAM (content = low byte of the address, one-cycle read latency)
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) begin
         rd_data0 <= rd_addr0[7:0];
         rd_data1 <= rd_addr1[7:0];
         rd_data2 <= rd_addr2[7:0];
         rd_data3 <= rd_addr3[7:0];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: pixel (ox,oy) samples source position (ox*step_x, oy*step_y).
   task automatic push_frame(input int sw, input int sh, input int dw, input int dh,
                             input int sx, input int sy);
      longint ax, ay;
      int ix, fx, iy, fy, x0, x1, y0, y1;
      logic [19:0] a0, a1, a2, a3;
      logic [9:0]  c1, c2, c3, c4;
      for (int oy = 0; oy < dh; oy++) begin
         for (int ox = 0; ox < dw; ox++) begin
            ax = (longint'(ox) * sx) % 1048576;
            ay = (longint'(oy) * sy) % 1048576;
            ix = int'(ax / 512);
            fx = int'(ax % 512);
            iy = int'(ay / 512);
            fy = int'(ay % 512);
            x0 = (ix > sw - 1) ? sw - 1 : ix;
            x1 = (ix + 1 > sw - 1) ? sw - 1 : ix + 1;
            y0 = (iy > sh - 1) ? sh - 1 : iy;
            y1 = (iy + 1 > sh - 1) ? sh - 1 : iy + 1;
            a0 = 20'(y0 * sw + x0);
            a1 = 20'(y0 * sw + x1);
            a2 = 20'(y1 * sw + x0);
            a3 = 20'(y1 * sw + x1);
            c1 = 10'(512 - fx);
            c2 = 10'(fx);
            c3 = 10'(512 - fy);
            c4 = 10'(fy);
            exp_addr_q.push_back({a0, a1, a2, a3});
            exp_out_q.push_back({a0[7:0], a1[7:0], a2[7:0], a3[7:0], c1, c2, c3, c4});
         end
      end
   endtask

   // Scoreboard compare: every read strobe and every en_b against the model queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_en) begin
            if (exp_addr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rd_addr: rd_en high with no read expected (addr0=%0h)", rd_addr0);
            end else begin
               check("rd_addr", {rd_addr0, rd_addr1, rd_addr2, rd_addr3}, exp_addr_q.pop_front());
            end
         end
         if (en_b) begin
            if (exp_out_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pixel_set: en_b high with no pixel expected (doutbx=%0h)", doutbx);
            end else begin
               check("pixel_set", {doutbx, doutbx1, doutby, doutby1,
                                   coefficient1, coefficient2, coefficient3, coefficient4},
                     exp_out_q.pop_front());
            end
         end
      end
   end

   // Drives one frame and checks its latency, pulse counts and done/busy timing.
   task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                            input int sx, input int sy, input int restart_at,
                            input bit start_on_done);
      int n, first_rd, first_en, n_en, last_en, done_at, n_busy, n_rd;
      n = dw * dh;
      first_rd = -1; first_en = -1; last_en = -1; done_at = -1;
      n_en = 0; n_busy = 0; n_rd = 0;
      src_w = DIM_W'(sw); src_h = DIM_W'(sh);
      dst_w = DIM_W'(dw); dst_h = DIM_W'(dh);
      step_x = ACC_W'(sx); step_y = ACC_W'(sy);
      push_frame(sw, sh, dw, dh, sx, sy);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < n + 40 && done_at < 0; c++) begin
         if (c > 0) @(negedge clk);
         if (busy) n_busy++;
         if (rd_en) begin
            if (first_rd < 0) first_rd = c;
            if (n_rd < 64) begin
               cap_a0[n_rd] = rd_addr0;
               cap_a1[n_rd] = rd_addr1;
            end
            n_rd++;
         end
         if (en_b) begin
            if (first_en < 0) first_en = c;
            if (n_en < 64) begin
               cap_dx[n_en] = doutbx;
               cap_c1[n_en] = coefficient1;
               cap_c2[n_en] = coefficient2;
               cap_c3[n_en] = coefficient3;
               cap_c4[n_en] = coefficient4;
            end
            n_en++;
            last_en = c;
         end
         if (done) done_at = c;
         if (c == restart_at) begin
            start = 1'b1;
            src_w = DIM_W'(sw + 1);
            dst_w = DIM_W'(dw + 3);
            step_x = ACC_W'(sx + 100);
         end else if (c == restart_at + 1) begin
            start = 1'b0;
            src_w = DIM_W'(sw);
            dst_w = DIM_W'(dw);
            step_x = ACC_W'(sx);
         end
      end
      check("first_rd_en_cycle", 80'(first_rd), 80'(3));
      check("first_en_b_cycle", 80'(first_en), 80'(5));
      check("en_b_count", 80'(n_en), 80'(n));
      check("last_en_b_cycle", 80'(last_en), 80'(4 + n));
      check("done_cycle", 80'(done_at), 80'(5 + n));
      check("busy_cycles", 80'(n_busy), 80'(n + 5));
      check("addr_queue_drained", 80'(exp_addr_q.size()), 80'(0));
      check("pixel_queue_drained", 80'(exp_out_q.size()), 80'(0));
      if (start_on_done) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("start_with_done_ignored", 80'(busy), 80'(0));
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit seen_done;
      repeat (3) @(negedge clk);
      check("rst_busy", 80'(busy), 80'(0));
      check("rst_done", 80'(done), 80'(0));
      check("rst_rd_en", 80'(rd_en), 80'(0));
      check("rst_en_b", 80'(en_b), 80'(0));
      check("rst_state", 80'(dbg_state), 80'(0));
      check("rst_addrs", {rd_addr0, rd_addr1, rd_addr2, rd_addr3}, 80'(0));
      check("rst_pixels", {doutbx, doutbx1, doutby, doutby1}, 80'(0));
      check("rst_coefs", {coefficient1, coefficient2, coefficient3, coefficient4}, 80'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Identity: 4x4 -> 4x4, unit step
      run_frame(4, 4, 4, 4, 512, 512, -1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("id_doutbx[%0d]", i), 80'(cap_dx[i]), 80'(i));
         check($sformatf("id_coefs[%0d]", i),
               {cap_c1[i], cap_c2[i], cap_c3[i], cap_c4[i]}, {10'd512, 10'd0, 10'd512, 10'd0});
      end

      // 2x upscale: 2x2 -> 4x4, half step
      run_frame(2, 2, 4, 4, 256, 256, -1, 1'b0);
      check("up_c1_x1", 80'(cap_c1[1]), 80'(256));
      check("up_c2_x1", 80'(cap_c2[1]), 80'(256));
      check("up_a0_x1", 80'(cap_a0[1]), 80'(0));
      check("up_a1_x1", 80'(cap_a1[1]), 80'(1));
      check("up_a0_x3", 80'(cap_a0[3]), 80'(1));
      check("up_a1_x3_clamped", 80'(cap_a1[3]), 80'(1));

      // Fractional step 1.5 over an 8-wide row; start held during done must be ignored
      run_frame(8, 1, 4, 1, 768, 512, -1, 1'b1);
      check("frac_a0_0", 80'(cap_a0[0]), 80'(0));
      check("frac_a0_1", 80'(cap_a0[1]), 80'(1));
      check("frac_a0_2", 80'(cap_a0[2]), 80'(3));
      check("frac_a0_3", 80'(cap_a0[3]), 80'(4));
      check("frac_c2_0", 80'(cap_c2[0]), 80'(0));
      check("frac_c2_1", 80'(cap_c2[1]), 80'(256));
      check("frac_c2_2", 80'(cap_c2[2]), 80'(0));
      check("frac_c2_3", 80'(cap_c2[3]), 80'(256));

      // Second start mid-frame with different configuration on the pins
      run_frame(5, 3, 7, 2, 300, 700, 4, 1'b0);

      // Reset mid-frame aborts without done, then a clean frame follows
      src_w = 4; src_h = 4; dst_w = 4; dst_h = 4; step_x = 512; step_y = 512;
      push_frame(4, 4, 4, 4, 512, 512);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_en_b", 80'(en_b), 80'(0));
      check("abort_rd_en", 80'(rd_en), 80'(0));
      check("abort_busy", 80'(busy), 80'(0));
      exp_addr_q.delete();
      exp_out_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      check("abort_no_done", 80'(seen_done), 80'(0));
      run_frame(3, 3, 5, 3, 400, 600, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
